ps2_kbd_rx: RTL and testbench

Parametrised PS/2 keyboard receiver for the NPC simulation top. It replaces the bare scancode/count pair with a validated event stream.
- Synchronises ps2_clk/ps2_data and deframes 11-bit frames with odd-parity and timeout checking.
- Folds E0/F0 prefixes into one {ext, brk, code} event.
- Buffers events in a FIFO drained by a valid/ready handshake.
- Keeps a key-press counter for the 7-seg display path.

---
 rtl/ps2_kbd_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise, deframe, fold E0/F0 prefixes, FIFO events, count presses.
// Optional define PS2_TYPEMATIC_FILTER_EN drops typematic repeats of the currently held key.
module ps2_kbd_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_brk,
    output logic [CNT_W-1:0] press_cnt,
    output logic             overflow,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {S_IDLE, S_RECV} state_t;

    // Reset: asynchronous assert, release aligned to clock
    logic [1:0] rst_pipe;
    logic       rst_int;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rst_pipe <= '1;
        else       rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign rst_int = rst_pipe[1];

    // Input synchronisers, preset to idle-high bus
    logic [SYNC_STAGES-1:0] clk_sh, dat_sh;
    logic                   sync_clk, sync_data, sync_clk_prev, fall;

    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) begin
            clk_sh        <= '1;
            dat_sh        <= '1;
            sync_clk_prev <= 1'b1;
        end else begin
            clk_sh        <= {clk_sh[SYNC_STAGES-2:0], ps2_clk};
            dat_sh        <= {dat_sh[SYNC_STAGES-2:0], ps2_data};
            sync_clk_prev <= sync_clk;
        end
    end
    assign sync_clk  = clk_sh[SYNC_STAGES-1];
    assign sync_data = dat_sh[SYNC_STAGES-1];
    assign fall      = sync_clk_prev & ~sync_clk;

    // Deframer FSM
    state_t          state, state_n;
    logic [3:0]      bitcnt, bitcnt_n;
    logic [TW-1:0]   timer, timer_n;
    logic [8:0]      shreg, shreg_n;
    logic            stop_edge, tmo, frame_good, frame_bad;

    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) begin
            state  <= S_IDLE;
            bitcnt <= '0;
            timer  <= '0;
            shreg  <= '0;
        end else begin
            state  <= state_n;
            bitcnt <= bitcnt_n;
            timer  <= timer_n;
            shreg  <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        bitcnt_n  = bitcnt;
        timer_n   = timer;
        shreg_n   = shreg;
        stop_edge = 1'b0;
        tmo       = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall && !sync_data) begin
                    state_n  = S_RECV;
                    bitcnt_n = '0;
                    timer_n  = '0;
                end
            end
            S_RECV: begin
                if (fall) begin
                    timer_n = '0;
                    if (bitcnt == 4'd9) begin
                        state_n   = S_IDLE;
                        stop_edge = 1'b1;
                    end else begin
                        // LSB first: after 9 shifts shreg = {parity, data[7:0]}
                        shreg_n  = {sync_data, shreg[8:1]};
                        bitcnt_n = bitcnt + 4'd1;
                    end
                end else if (timer == TMO_LAST) begin
                    state_n = S_IDLE;
                    tmo     = 1'b1;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
        frame_good = stop_edge & (^shreg) & sync_data;
        frame_bad  = (stop_edge & ~frame_good) | tmo;
    end

    // Prefix folding and event staging
    logic [7:0] rx_byte;
    logic       is_e0, is_f0, key_evt, ev_keep;
    logic       ext_pend, brk_pend;
    logic       ev_vld, ev_ext, ev_brk;
    logic [7:0] ev_code;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_vld, held_ext, held_hit;
    logic [7:0] held_code;
`endif

    always_comb begin
        rx_byte = shreg[7:0];
        is_e0   = (rx_byte == 8'hE0);
        is_f0   = (rx_byte == 8'hF0);
        key_evt = frame_good & ~is_e0 & ~is_f0;
        ev_keep = key_evt;
`ifdef PS2_TYPEMATIC_FILTER_EN
        held_hit = held_vld && (held_ext == ext_pend) && (held_code == rx_byte);
        if (!brk_pend && held_hit) ev_keep = 1'b0;
`endif
    end

    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            ev_vld   <= 1'b0;
            ev_ext   <= 1'b0;
            ev_brk   <= 1'b0;
            ev_code  <= '0;
        end else begin
            ev_vld <= ev_keep;
            if (ev_keep) begin
                ev_ext  <= ext_pend;
                ev_brk  <= brk_pend;
                ev_code <= rx_byte;
            end
            if (frame_good) begin
                if (is_e0) begin
                    ext_pend <= 1'b1;
                end else if (is_f0) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) begin
            held_vld  <= 1'b0;
            held_ext  <= 1'b0;
            held_code <= '0;
        end else if (key_evt) begin
            if (brk_pend) begin
                if (held_hit) held_vld <= 1'b0;
            end else if (!held_hit) begin
                held_vld  <= 1'b1;
                held_ext  <= ext_pend;
                held_code <= rx_byte;
            end
        end
    end
`endif

    // Event FIFO, first-word-fall-through
    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, accept;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = ~empty & evt_ready;
    assign accept = ev_vld & (~full | pop);

    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= {ev_ext, ev_brk, ev_code};
    end

    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            press_cnt <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)    rd_ptr <= rd_ptr + (AW+1)'(1);
            if (accept && !ev_brk) press_cnt <= press_cnt + CNT_W'(1);
            if (ev_vld && full && !pop) overflow <= 1'b1;
            else if (clr_err)           overflow <= 1'b0;
            if (frame_bad)              frame_err <= 1'b1;
            else if (clr_err)           frame_err <= 1'b0;
        end
    end

    assign evt_valid = ~empty;
    assign {evt_ext, evt_brk, evt_code} = empty ? 10'd0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx with an event-level reference model checked every quiet cycle.
module tb_ps2_kbd_rx;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int HALF  = 8;

    logic       clock = 1'b0, reset = 1'b1;
    logic       ps2_clk = 1'b1, ps2_data = 1'b1, evt_ready = 1'b0, clr_err = 1'b0;
    logic       evt_valid, evt_ext, evt_brk, overflow, frame_err;
    logic [7:0] evt_code, press_cnt;

    always #5 clock = ~clock;

    ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(8), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)) dut (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_brk(evt_brk), .press_cnt(press_cnt),
        .overflow(overflow), .frame_err(frame_err), .clr_err(clr_err)
    );

    int vectors = 0, miscompares = 0;

    // Model: expected FIFO contents {ext,brk,code} and flag state
    logic [9:0] mq[$];
    logic       m_ext = 0, m_brk = 0, m_ovf = 0, m_ferr = 0;
    logic [7:0] m_cnt = 0;
    logic       h_vld = 0, h_ext = 0;
    logic [7:0] h_code = 0;
    bit         quiet = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic model_rx(input logic [7:0] b, input bit good);
        bit keep;
        keep = 1;
        if (!good) begin
            m_ferr = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (h_vld && h_ext == m_ext && h_code == b) begin
                if (m_brk) h_vld = 0;
                else       keep = 0;
            end else if (!m_brk) begin
                h_vld = 1; h_ext = m_ext; h_code = b;
            end
`endif
            if (keep) begin
                if (mq.size() == DEPTH) m_ovf = 1;
                else begin
                    mq.push_back({m_ext, m_brk, b});
                    if (!m_brk) m_cnt = m_cnt + 8'd1;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // Drive start + nbits data bits, then leave the bus idle
    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, ~^b, b, 1'b0};
        quiet = 0;
        for (int i = 0; i <= nbits; i++) begin
            ps2_data = bits[i]; tick(HALF);
            ps2_clk = 0;        tick(HALF);
            ps2_clk = 1;
        end
        ps2_data = 1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit lat);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        quiet = 0;
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i]; tick(HALF);
            ps2_clk = 0;
            if (lat && i == 10) begin
                // fall seen by synchroniser at 1st posedge, detected in cycle after 2nd
                repeat (4) @(negedge clock);
                chk("latency_pre", evt_valid, 0);
                @(negedge clock);
                chk("latency_post", evt_valid, 1);
            end
            tick(HALF);
            ps2_clk = 1;
        end
        ps2_data = 1;
        tick(4);
        model_rx(b, !bad_par && !bad_stop);
        quiet = 1;
        tick(HALF);
    endtask

    task automatic drain();
        evt_ready = 1;
        for (int i = 0; i < 40 && mq.size() != 0; i++) tick(1);
        chk("drain_done", mq.size(), 0);
        evt_ready = 0;
        tick(2);
    endtask

    task automatic clear_err();
        clr_err = 1; tick(1);
        clr_err = 0; m_ferr = 0; m_ovf = 0;
        tick(1);
    endtask

    task automatic do_reset();
        quiet = 0;
        reset = 1; ps2_clk = 1; ps2_data = 1; evt_ready = 0;
        tick(3);
        reset = 0;
        mq.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_ferr = 0; m_cnt = 0; h_vld = 0;
        tick(5);
        quiet = 1;
    endtask

    always @(negedge clock) begin
        if (quiet) begin
            chk("evt_valid", evt_valid, mq.size() != 0);
            if (mq.size() != 0) chk("evt_head", {evt_ext, evt_brk, evt_code}, mq[0]);
            chk("press_cnt", press_cnt, m_cnt);
            chk("overflow", overflow, m_ovf);
            chk("frame_err", frame_err, m_ferr);
            if (evt_valid && evt_ready && mq.size() != 0) void'(mq.pop_front());
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tick(3);
        reset = 0;
        tick(5);
        chk("rst_valid", evt_valid, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_cnt", press_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        quiet = 1;

        // Single make with latency check
        send_frame(8'h1C, 0, 0, 1);
        chk("t1_code", {evt_ext, evt_brk, evt_code}, 10'h01C);
        chk("t1_cnt", press_cnt, 1);
        drain();

        // Extended break folds into one event
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        chk("t2_noevt", evt_valid, 0);
        send_frame(8'h75, 0, 0, 0);
        chk("t2_evt", {evt_ext, evt_brk, evt_code}, 10'h375);
        chk("t2_cnt", press_cnt, 1);
        drain();

        // Parity error, clear, recover
        send_frame(8'h1C, 1, 0, 0);
        chk("t3_ferr", frame_err, 1);
        chk("t3_noevt", evt_valid, 0);
        clear_err();
        chk("t3_clr", frame_err, 0);
        send_frame(8'h1B, 0, 0, 0);
        chk("t3_code", evt_code, 8'h1B);
        drain();

        // Overflow: DEPTH+1 makes with consumer stalled
        do_reset();
        for (int c = 1; c <= DEPTH + 1; c++) send_frame(8'(c), 0, 0, 0);
        chk("t4_model_n", mq.size(), DEPTH);
        chk("t4_head", evt_code, 8'h01);
        chk("t4_ovf", overflow, 1);
        chk("t4_cnt", press_cnt, 8);
        drain();
        chk("t4_ovf_sticky", overflow, 1);
        clear_err();
        chk("t4_ovf_clr", overflow, 0);

        // Bad stop bit, then mid-frame timeout, then recovery
        send_frame(8'h33, 0, 1, 0);
        chk("t5_stop_ferr", frame_err, 1);
        clear_err();
        send_partial(8'h2A, 4);
        tick(TMO + 20);
        m_ferr = 1;
        quiet = 1;
        chk("t5_tmo_ferr", frame_err, 1);
        clear_err();
        send_frame(8'h2A, 0, 0, 0);
        chk("t5_code", evt_code, 8'h2A);
        drain();

        // Reset mid-frame, then typematic sequence
        send_partial(8'h55, 3);
        do_reset();
        send_frame(8'h1B, 0, 0, 0);
        send_frame(8'h1B, 0, 0, 0);
        send_frame(8'h1B, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1B, 0, 0, 0);
`ifdef PS2_TYPEMATIC_FILTER_EN
        chk("t6_model_n", mq.size(), 2);
        chk("t6_cnt", press_cnt, 1);
`else
        chk("t6_model_n", mq.size(), 4);
        chk("t6_cnt", press_cnt, 3);
`endif
        chk("t6_head", evt_code, 8'h1B);
        drain();

        quiet = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
